// File: rtl/discrete_pkg.sv
// ============================================================================
// Module      : discrete_pkg
// Description : Shared types and elaboration helpers for the discrete RC stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package discrete_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    UPDATE = 2'd2
  } rc_filter_state_t;

  localparam int RC_COEF_BITS = 16;
  localparam int RC_MIN_CLOCKS_PER_SAMPLE = 20;

  // Smoothing factor alpha = dt / (RC + dt) in Q0.16, saturated to 1..65535.
  function automatic logic [15:0] rc_alpha_16(input longint sample_rate,
                                              input longint r,
                                              input longint c_16_shifted);
    longint dt_us_16;
    longint rc_us_16;
    longint alpha;
    dt_us_16 = (longint'(1000000) << 16) / sample_rate;
    rc_us_16 = r * c_16_shifted;
    alpha    = (dt_us_16 << 16) / (rc_us_16 + dt_us_16);
    if (alpha > 65535) alpha = 65535;
    if (alpha < 1) alpha = 1;
    return alpha[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_mult_17x16.sv
// ============================================================================
// Module      : serial_mult_17x16
// Description : Shift-and-add signed 17 x unsigned 16 multiplier, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_mult_17x16 (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [16:0] multiplicand,
  input  logic        [15:0] multiplier,
  output logic               done,
  output logic signed [32:0] product
);

  logic signed [32:0] r_mcand;
  logic        [15:0] r_mplier;
  logic        [3:0]  r_count;
  logic               r_busy;
  logic signed [32:0] r_acc;

  // done marks the cycle in which the final partial product is being added
  assign done    = r_busy && (r_count == 4'd15);
  assign product = r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_acc    <= '0;
    end else if (start) begin
      r_mcand  <= {{16{multiplicand[16]}}, multiplicand};
      r_mplier <= multiplier;
      r_count  <= '0;
      r_busy   <= 1'b1;
      r_acc    <= '0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand <<< 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 4'd1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rc_lowpass_filter.sv
// ============================================================================
// Module      : rc_lowpass_filter
// Description : First-order RC low-pass, y += alpha*(in - y), serial multiply.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rc_lowpass_filter
  import discrete_pkg::*;
#(
  parameter int CLOCK_RATE   = 50000000,
  parameter int SAMPLE_RATE  = 48000,
  parameter int R            = 1000,
  parameter int C_16_SHIFTED = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        audio_clk_en,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        out_valid
);

  localparam logic [15:0] ALPHA_16 = rc_alpha_16(longint'(SAMPLE_RATE),
                                                 longint'(R),
                                                 longint'(C_16_SHIFTED));

  generate
    if (CLOCK_RATE / SAMPLE_RATE < RC_MIN_CLOCKS_PER_SAMPLE) begin : g_rate_check
      $error("rc_lowpass_filter: CLOCK_RATE/SAMPLE_RATE too small for serial multiply");
    end
  endgenerate

  rc_filter_state_t   r_state;
  rc_filter_state_t   w_state_next;
  logic        [15:0] r_y;
  logic               r_pend_valid;
  logic        [15:0] r_pend_data;

  logic               w_capture;
  logic        [15:0] w_cap_sample;
  logic signed [16:0] w_diff;
  logic               w_mult_done;
  logic signed [32:0] w_product;
  logic signed [17:0] w_y_sum;
  logic        [15:0] w_y_clamped;

  // A fresh strobe is newer than anything waiting in the pending register
  assign w_cap_sample = audio_clk_en ? in : r_pend_data;
  assign w_diff       = $signed({1'b0, w_cap_sample}) - $signed({1'b0, r_y});

  serial_mult_17x16 u_mult (
    .clk          (clk),
    .reset        (reset),
    .start        (w_capture),
    .multiplicand (w_diff),
    .multiplier   (ALPHA_16),
    .done         (w_mult_done),
    .product      (w_product)
  );

  always_comb begin
    w_y_sum = 18'($signed({17'd0, r_y}) + (w_product >>> 16));
    if (w_y_sum[17]) begin
      w_y_clamped = '0;
    end else if (w_y_sum[16]) begin
      w_y_clamped = 16'hFFFF;
    end else begin
      w_y_clamped = w_y_sum[15:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (audio_clk_en || r_pend_valid) begin
          w_capture    = 1'b1;
          w_state_next = MULT;
        end
      end
      MULT: begin
        if (w_mult_done) begin
          w_state_next = UPDATE;
        end
      end
      UPDATE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_y          <= '0;
      out_valid    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else begin
      r_state   <= w_state_next;
      out_valid <= 1'b0;
      if (r_state == UPDATE) begin
        r_y       <= w_y_clamped;
        out_valid <= 1'b1;
      end
      if (w_capture) begin
        r_pend_valid <= 1'b0;
      end else if (audio_clk_en && (r_state != IDLE)) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= in;
      end
    end
  end

  assign out = r_y;

endmodule

`default_nettype wire

// File: tb/tb_rc_lowpass_filter.sv
// ============================================================================
// Module      : tb_rc_lowpass_filter
// Description : Self-checking bench for rc_lowpass_filter (default and R=0 builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rc_lowpass_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en0 = 1'b0;
  logic        en1 = 1'b0;
  logic [15:0] in0 = '0;
  logic [15:0] in1 = '0;
  logic [15:0] out0;
  logic [15:0] out1;
  logic        v0;
  logic        v1;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  rc_lowpass_filter dut (
    .clk          (clk),
    .reset        (rst),
    .audio_clk_en (en0),
    .in           (in0),
    .out          (out0),
    .out_valid    (v0)
  );

  rc_lowpass_filter #(
    .CLOCK_RATE   (50000000),
    .SAMPLE_RATE  (48000),
    .R            (0),
    .C_16_SHIFTED (65536)
  ) dut_fast (
    .clk          (clk),
    .reset        (rst),
    .audio_clk_en (en1),
    .in           (in1),
    .out          (out1),
    .out_valid    (v1)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_y      [2] = '{0, 0};
  int m_x      [2] = '{0, 0};
  int m_done_at[2] = '{0, 0};
  int m_pend_d [2] = '{0, 0};
  bit m_busy   [2] = '{1'b0, 1'b0};
  bit m_pend_v [2] = '{1'b0, 1'b0};
  bit m_valid  [2] = '{1'b0, 1'b0};

  function automatic int alpha_of(input int i);
    return (i == 1) ? 65535 : 1337;
  endfunction

  function automatic bit en_of(input int i);
    return (i == 1) ? en1 : en0;
  endfunction

  function automatic int in_of(input int i);
    return (i == 1) ? int'(in1) : int'(in0);
  endfunction

  // y + floor((x - y) * alpha / 65536), clamped to the 16-bit range
  function automatic int filt(input int y, input int x, input int alpha);
    longint p;
    longint q;
    int     r;
    p = longint'(x - y) * longint'(alpha);
    q = p / 65536;
    if ((p < 0) && ((p % 65536) != 0)) q = q - 1;
    r = y + int'(q);
    if (r < 0) r = 0;
    if (r > 65535) r = 65535;
    return r;
  endfunction

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_y[i] = 0; m_busy[i] = 1'b0; m_pend_v[i] = 1'b0; m_valid[i] = 1'b0;
      end else begin
        m_valid[i] = 1'b0;
        if (m_busy[i]) begin
          if (edge_n + 1 == m_done_at[i]) begin
            m_y[i]     = filt(m_y[i], m_x[i], alpha_of(i));
            m_valid[i] = 1'b1;
            m_busy[i]  = 1'b0;
          end
          if (en_of(i)) begin
            m_pend_v[i] = 1'b1;
            m_pend_d[i] = in_of(i);
          end
        end else if (en_of(i) || m_pend_v[i]) begin
          m_x[i]       = en_of(i) ? in_of(i) : m_pend_d[i];
          m_pend_v[i]  = 1'b0;
          m_busy[i]    = 1'b1;
          m_done_at[i] = edge_n + 1 + 17;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (edge_n > 0) begin
      check("out0",   longint'(out0), longint'(m_y[0]));
      check("valid0", longint'(v0),   longint'(m_valid[0]));
      check("out1",   longint'(out1), longint'(m_y[1]));
      check("valid1", longint'(v1),   longint'(m_valid[1]));
    end
  end

  // ---------------- stimulus ----------------
  // Runs n cycles; strobes at offsets s0..s2, reset at rst_at; pulse offsets
  // are reported relative to the edge that sampled the offset-0 strobe.
  task automatic run_window(input int sel, input int n,
                            input int s0, input int s1, input int s2,
                            input int d0, input int d1, input int d2,
                            input int rst_at,
                            output int npulse, output int e0, output int e1,
                            output int q0, output int q1);
    int t0;
    bit e;
    int d;
    npulse = 0; e0 = -1; e1 = -1; q0 = -1; q1 = -1; t0 = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) t0 = edge_n + 1;
      if (c > 0 && ((sel == 1) ? v1 : v0)) begin
        if (npulse == 0) begin
          e0 = edge_n - t0; q0 = int'((sel == 1) ? out1 : out0);
        end else if (npulse == 1) begin
          e1 = edge_n - t0; q1 = int'((sel == 1) ? out1 : out0);
        end
        npulse++;
      end
      e = (c == s0) || (c == s1) || (c == s2);
      d = (c == s0) ? d0 : (c == s1) ? d1 : d2;
      if (sel == 1) begin en1 = e; in1 = 16'(d); end
      else begin en0 = e; in0 = 16'(d); end
      rst = (c == rst_at);
    end
    @(negedge clk);
    en0 = 1'b0; en1 = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int np, e0, e1, q0, q1, rv, prev;
    rv = 0;
    // reset held with strobes toggling
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c > 0) rv += int'(v0) + int'(v1);
      en0 = (c % 2 == 0); en1 = (c % 2 == 1);
      in0 = 16'hFFFF; in1 = 16'hFFFF;
    end
    @(negedge clk);
    rv += int'(v0) + int'(v1);
    rst = 1'b0; en0 = 1'b0; en1 = 1'b0;
    check("reset_valid_count", rv, 0);
    check("reset_out0", longint'(out0), 0);

    // step towards full scale from zero
    run_window(0, 25, 0, -1, -1, 65535, 0, 0, -1, np, e0, e1, q0, q1);
    check("step1_pulses", np, 1);
    check("step1_latency", e0, 17);
    check("step1_out", q0, 1336);
    run_window(0, 25, 0, -1, -1, 65535, 0, 0, -1, np, e0, e1, q0, q1);
    check("step2_out", q0, 2645);
    check("model_pin_2645", m_y[0], 2645);

    // zero input from reset: one pulse per strobe, output stays 0
    run_window(0, 3, -1, -1, -1, 0, 0, 0, 0, np, e0, e1, q0, q1);
    rv = 0;
    for (int k = 0; k < 3; k++) begin
      run_window(0, 21, 0, -1, -1, 0, 0, 0, -1, np, e0, e1, q0, q1);
      rv += np;
      check("zero_out", q0, 0);
    end
    check("zero_pulse_count", rv, 3);

    // R=0 build: near-instant tracking, then drop to zero with clamp
    run_window(1, 21, 0, -1, -1, 65535, 0, 0, -1, np, e0, e1, q0, q1);
    check("fast_rise", q0, 65534);
    prev = q0;
    run_window(1, 21, 0, -1, -1, 65535, 0, 0, -1, np, e0, e1, q0, q1);
    check("fast_hold", q0, 65534);
    prev = q0;
    for (int k = 0; k < 3; k++) begin
      run_window(1, 21, 0, -1, -1, 0, 0, 0, -1, np, e0, e1, q0, q1);
      check("fast_fall_monotonic", longint'(q0 <= prev), 1);
      check("fast_fall_value", q0, 0);
      prev = q0;
    end

    // overlapping strobes: newest pending sample wins
    run_window(0, 3, -1, -1, -1, 0, 0, 0, 0, np, e0, e1, q0, q1);
    run_window(0, 45, 0, 5, 9, 1000, 2000, 40000, -1, np, e0, e1, q0, q1);
    check("ovl_pulses", np, 2);
    check("ovl_first_latency", e0, 17);
    check("ovl_first_out", q0, 20);
    check("ovl_second_latency", e1, 35);
    check("ovl_second_out", q1, 835);

    // reset mid-computation aborts it
    run_window(0, 40, 0, -1, -1, 500, 0, 0, 10, np, e0, e1, q0, q1);
    check("abort_pulses", np, 0);
    check("abort_out", longint'(out0), 0);
    run_window(0, 25, 0, -1, -1, 500, 0, 0, -1, np, e0, e1, q0, q1);
    check("post_abort_latency", e0, 17);
    check("post_abort_out", q0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
